// File: rtl/ucode_seq_ctrl_if.sv
// Program-memory bus between the instruction sequencer (master) and synchronous program memory (slave).
// Read data is expected the cycle after imem_rd is asserted.
interface ucode_seq_ctrl_if #(
    parameter int unsigned PC_W = 12
) ();
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [23:0]     imem_data;

    modport master (output imem_addr, output imem_rd, input imem_data);
    modport slave  (input imem_addr, input imem_rd, output imem_data);
endinterface

// File: rtl/ucode_seq_ctrl.sv
// Microprogram instruction sequencer: FETCH/LOAD/DECODE/EXEC loop with control-flow resolution.
// Optional return stack for BSR/RET enabled by defining UCODE_SEQ_STACK_EN.
module ucode_seq_ctrl #(
    parameter int unsigned PC_W        = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             zero_flag,
    input  logic             carry_flag,
    ucode_seq_ctrl_if.master imem,
    output logic [23:0]      ir_out,
    output logic             exec_en,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             stack_err
);

    if ((STACK_DEPTH < 2) || ((STACK_DEPTH & (STACK_DEPTH - 1)) != 0)) begin : g_depth_check
        $error("ucode_seq_ctrl: STACK_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] target;
    logic            fault;

    assign imem.imem_addr = pc;
    assign pc_inc         = pc + PC_W'(1);
    assign target         = ir_out[PC_W-1:0];

`ifdef UCODE_SEQ_STACK_EN
    localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

    logic [PC_W-1:0] stack [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-2:0] sp_top;
    logic            do_push;
    logic            do_pop;

    assign sp_top = sp[SP_W-2:0] - (SP_W-1)'(1);
`else
    assign stack_err = 1'b0;
`endif

    always_comb begin
        pc_next = pc_inc;
        fault   = 1'b0;
`ifdef UCODE_SEQ_STACK_EN
        do_push = 1'b0;
        do_pop  = 1'b0;
`endif
        if (ir_out[23:19] == 5'b10000) begin
            case (ir_out[18:12])
                7'd0: pc_next = target;
                7'd1: if (zero_flag)  pc_next = target;
                7'd2: if (!zero_flag) pc_next = target;
                7'd3: if (carry_flag) pc_next = target;
`ifdef UCODE_SEQ_STACK_EN
                7'd4: begin
                    if (sp == '0) begin
                        fault   = 1'b1;
                        pc_next = pc;
                    end else begin
                        do_pop  = 1'b1;
                        pc_next = stack[sp_top];
                    end
                end
                7'd5: begin
                    if (sp == SP_W'(STACK_DEPTH)) begin
                        fault   = 1'b1;
                        pc_next = pc;
                    end else begin
                        do_push = 1'b1;
                        pc_next = target;
                    end
                end
`endif
                default: pc_next = pc_inc;
            endcase
        end
    end

    // imem_rd, exec_en and busy are registered: each is set on the edge entering its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= '0;
            ir_out       <= '0;
            imem.imem_rd <= 1'b0;
            exec_en      <= 1'b0;
            busy         <= 1'b0;
`ifdef UCODE_SEQ_STACK_EN
            sp           <= '0;
            stack_err    <= 1'b0;
`endif
        end else begin
            imem.imem_rd <= 1'b0;
            exec_en      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state        <= S_FETCH;
                        imem.imem_rd <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    ir_out <= imem.imem_data;
                    state  <= S_DECODE;
                end
                S_DECODE: begin
                    state   <= S_EXEC;
                    exec_en <= 1'b1;
                end
                S_EXEC: begin
                    if (fault) begin
`ifdef UCODE_SEQ_STACK_EN
                        stack_err <= 1'b1;
`endif
                        busy  <= 1'b0;
                        state <= S_HALT;
                    end else begin
`ifdef UCODE_SEQ_STACK_EN
                        if (do_push) begin
                            stack[sp[SP_W-2:0]] <= pc_inc;
                            sp                  <= sp + SP_W'(1);
                        end
                        if (do_pop) begin
                            sp <= sp - SP_W'(1);
                        end
`endif
                        pc <= pc_next;
                        if (run) begin
                            state        <= S_FETCH;
                            imem.imem_rd <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                S_HALT: state <= S_HALT;
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ucode_seq_ctrl.md
# ucode_seq_ctrl

Instruction sequencer for the microprogrammed CPU. It owns the program counter and fetches 24-bit instructions from synchronous program memory. It presents each instruction to the microinstruction decoder, strobes execution of the resulting microinstruction, and resolves control-flow instructions (JMP/JZE/JNE/JCY/BSR/RET) against the ALU flags through a hardware return stack. It sits between program memory, the decoder and the datapath.

## Interface
- `PC_W`, default 12: program counter / memory address width; equals the instruction target field IR[11:0].
- `STACK_DEPTH`, default 4: return-stack entries; must be a power of two and at least 2.
- `clk` input, 1 bit: single clock; all state updates on rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `run` input, 1 bit: level; high permits fetching new instructions.
- `zero_flag` input, 1 bit: ALU zero flag, valid in EXEC.
- `carry_flag` input, 1 bit: ALU carry flag, valid in EXEC.
- `imem_data` input, 24 bits: program memory read data; valid the cycle after `imem_rd`.
- `imem_addr` output, PC_W bits: program memory address, always equal to `pc`.
- `imem_rd` output, 1 bit: memory read strobe.
- `ir_out` output, 24 bits: latched instruction to the decoder.
- `exec_en` output, 1 bit: one-cycle strobe; the datapath commits the decoder's microinstruction.
- `pc` output, PC_W bits: current program counter.
- `busy` output, 1 bit: high in any state except IDLE and HALT.
- `stack_err` output, 1 bit: sticky return-stack overflow/underflow.

## Operation
- States: IDLE, FETCH, LOAD, DECODE, EXEC, HALT.
- IDLE: if `run`=1, go to FETCH; otherwise stay.
- FETCH: `imem_rd`=1, `imem_addr`=pc; go to LOAD.
- LOAD: `ir_out` <= `imem_data`; go to DECODE.
- DECODE: `ir_out` is stable for the decoder's registered lookup; go to EXEC.
- EXEC: `exec_en`=1 for exactly this cycle.
  - Resolve the next pc.
  - Go to FETCH if `run`=1, else IDLE.
- Control-flow decode applies only when IR[23:19]=5'b10000. Sub-op is IR[18:12]; target T is IR[11:0].
  - 0 JMP: pc <= T.
  - 1 JZE: pc <= T if `zero_flag`=1, else pc+1.
  - 2 JNE: pc <= T if `zero_flag`=0, else pc+1.
  - 3 JCY: pc <= T if `carry_flag`=1, else pc+1.
  - 4 RET: pc <= top of stack; pop.
  - 5 BSR: push pc+1; pc <= T.
  - 6, 7 and any other sub-op: pc <= pc+1.
- All other groups: pc <= pc+1. pc arithmetic wraps modulo 2^PC_W, so 0xFFF+1 = 0x000.
- Return stack: LIFO, STACK_DEPTH entries, pointer sp from 0 to STACK_DEPTH.
  - BSR with sp=STACK_DEPTH is an overflow: set `stack_err`, go to HALT, no push, pc unchanged.
  - RET with sp=0 is an underflow: set `stack_err`, go to HALT, pc unchanged.
- HALT: `exec_en` and `imem_rd` stay 0. Only `rst` exits HALT.
- `run` dropping mid-instruction: the current instruction completes through EXEC, then the block goes to IDLE. `run`=1 in IDLE resumes at the current pc.
- Reset values: `pc`=0, `ir_out`=0, `imem_rd`=0, `exec_en`=0, `busy`=0, `stack_err`=0, sp=0, state=IDLE.
- Reset mid-operation: state is discarded at the next edge regardless of state. `exec_en` is never asserted in the cycle following `rst`.

## Timing
- 4 cycles per instruction: FETCH, LOAD, DECODE, EXEC. Back-to-back throughput is one instruction per 4 cycles.
- `run` asserted in cycle n (IDLE): FETCH occurs in n+1 and the first `exec_en` in n+4.
- Flags are sampled only in EXEC. They reflect the last committed microinstruction.
- pc update and the stack push/pop take effect at the EXEC clock edge. The new `imem_addr` is visible in the following FETCH.
- `ir_out` holds from LOAD until the next LOAD.

## Configuration
- `UCODE_SEQ_STACK_EN` defined: return stack implemented; BSR and RET behave as specified above.
- `UCODE_SEQ_STACK_EN` undefined: no stack storage.
  - BSR and RET are treated as pc <= pc+1.
  - `stack_err` is tied to 0.
  - HALT is unreachable.

## Test plan
- Reset, then `run`=1, memory holds 0x000000 at 0..3 → `exec_en` pulses every 4 cycles; pc goes 0,1,2,3; first pulse 4 cycles after `run`.
- At pc=5, IR=0x801040 (JZE 0x040): with `zero_flag`=1 the next `imem_addr`=0x040; with `zero_flag`=0 it is 0x006.
- At pc=0x010, IR=0x805100 (BSR 0x100); memory[0x100]=0x804000 (RET) → execution at 0x100, then back at 0x011; sp returns to 0.
- Five nested BSR with STACK_DEPTH=4 → `stack_err`=1 after the fifth EXEC; state HALT; no further `exec_en`; `rst` clears it.
- pc=0xFFF with a non-branch instruction → next pc=0x000. `run` dropped during LOAD → that instruction's `exec_en` still occurs, then IDLE with `busy`=0.
- Macro undefined: BSR at 0x010 → next pc=0x011 and `stack_err` stays 0. `rst` asserted during DECODE → next cycle pc=0, state IDLE, `exec_en`=0.
